// File: rtl/mbist_pkg.sv
// -----------------------------------------------------------------------------
// mbist_pkg
// Shared definitions for the MBIST algorithm scheduler.
//   NUM_ALGOS  : number of algorithm slots (slot k issues select code k+1)
//   SEL_*      : 4-bit algorithm-select codes understood by the control decoder
//   state_e    : sequencer FSM states
//   scan_t     : result of searching the run mask for the next algorithm
//   find_next  : lowest set mask bit at or above a starting slot
//   sel_code   : slot index to select code
// -----------------------------------------------------------------------------
package mbist_pkg;

   localparam int NUM_ALGOS = 6;

   localparam logic [3:0] SEL_NONE     = 4'd0;
   localparam logic [3:0] SEL_BG0      = 4'd1;
   localparam logic [3:0] SEL_BLN      = 4'd2;
   localparam logic [3:0] SEL_C1       = 4'd3;
   localparam logic [3:0] SEL_C1_REV   = 4'd4;
   localparam logic [3:0] SEL_MARCH_C  = 4'd5;
   localparam logic [3:0] SEL_MARCH_LR = 4'd6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_ISSUE,
      ST_RUN,
      ST_CLEAR,
      ST_FINISH
   } state_e;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } scan_t;

   // Walks from the top slot down so the last hit is the lowest eligible slot.
   function automatic scan_t find_next(input logic [NUM_ALGOS-1:0] mask,
                                       input logic [2:0]           from);
      scan_t r;
      r.found = 1'b0;
      r.idx   = 3'd0;
      for (int k = NUM_ALGOS - 1; k >= 0; k--) begin
         if (mask[k] && (3'(k) >= from)) begin
            r.found = 1'b1;
            r.idx   = 3'(k);
         end
      end
      return r;
   endfunction

   function automatic logic [3:0] sel_code(input logic [2:0] idx);
      case (idx)
         3'd0:    return SEL_BG0;
         3'd1:    return SEL_BLN;
         3'd2:    return SEL_C1;
         3'd3:    return SEL_C1_REV;
         3'd4:    return SEL_MARCH_C;
         3'd5:    return SEL_MARCH_LR;
         default: return SEL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mbist_watchdog.sv
// -----------------------------------------------------------------------------
// mbist_watchdog
// Per-algorithm watchdog. Present only when MBIST_SEQ_TIMEOUT_EN is defined.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (asserted while the algorithm is being issued)
//   enable     : count this cycle (asserted in every RUN cycle)
//   expire     : the current enabled cycle brings the count to 2^W-1, so the
//                sequencer leaves RUN after exactly 2^W-1 RUN cycles
// -----------------------------------------------------------------------------
`ifdef MBIST_SEQ_TIMEOUT_EN
module mbist_watchdog #(
   parameter int W = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [W-1:0] LAST = '1;

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expire = enable && (count == (LAST - 1'b1));

endmodule
`endif

// File: rtl/mbist_sequencer.sv
// -----------------------------------------------------------------------------
// mbist_sequencer
// Steps through the enabled MBIST algorithms in slot order, drives each select
// code to the control decoder, waits for the engine, pulses rst_done to clear
// the decoder and accumulates a per-algorithm pass/fail map.
//
// Optional feature: define MBIST_SEQ_TIMEOUT_EN to add a per-algorithm
// watchdog (TIMEOUT_W bits). Without it RUN waits indefinitely for algo_done.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : rising edge while idle launches a run
//   algo_mask  : slots to run, captured at launch
//   algo_done  : engine finished the current algorithm (honoured in RUN only)
//   algo_fail  : engine miscompare, sampled with algo_done
//   select     : algorithm code to the decoder, 0 = none
//   rst_done   : one-cycle decoder clear after each algorithm
//   busy       : run in progress
//   done       : run complete, held until next launch
//   pass       : valid with done, 1 when fail_map is all zero
//   fail_map   : bit k set when slot k failed or timed out
//   cur_algo   : slot being issued or run
// -----------------------------------------------------------------------------
module mbist_sequencer
   import mbist_pkg::*;
`ifdef MBIST_SEQ_TIMEOUT_EN
#(
   parameter int TIMEOUT_W = 16
)
`endif
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [NUM_ALGOS-1:0] algo_mask,
   input  logic                 algo_done,
   input  logic                 algo_fail,
   output logic [3:0]           select,
   output logic                 rst_done,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [NUM_ALGOS-1:0] fail_map,
   output logic [2:0]           cur_algo
);

   state_e                 state_q, state_d;
   logic [NUM_ALGOS-1:0]   mask_q, mask_d;
   logic                   start_q;
   logic [3:0]             select_d;
   logic                   rst_done_d, busy_d, done_d, pass_d;
   logic [NUM_ALGOS-1:0]   fail_map_d;
   logic [2:0]             cur_algo_d;
   scan_t                  scan;
   logic                   wd_expire;

`ifdef MBIST_SEQ_TIMEOUT_EN
   logic wd_clear, wd_enable;

   assign wd_clear  = (state_q == ST_ISSUE);
   assign wd_enable = (state_q == ST_RUN);

   mbist_watchdog #(
      .W (TIMEOUT_W)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (wd_clear),
      .enable (wd_enable),
      .expire (wd_expire)
   );
`else
   assign wd_expire = 1'b0;
`endif

   // NOTE: every register here uses <= so all of them update from the same
   // pre-edge values; blocking assignments would make the order of lines matter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         mask_q   <= '0;
         start_q  <= 1'b0;
         select   <= SEL_NONE;
         rst_done <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         fail_map <= '0;
         cur_algo <= 3'd0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         start_q  <= start;
         select   <= select_d;
         rst_done <= rst_done_d;
         busy     <= busy_d;
         done     <= done_d;
         pass     <= pass_d;
         fail_map <= fail_map_d;
         cur_algo <= cur_algo_d;
      end
   end

   // Outputs are registered: select/rst_done take their value on entry to the
   // state that owns them, and the completion flags are written as FINISH exits.
   always_comb begin
      // NOTE: every signal gets a hold value first so no path through the
      // case statement leaves one unassigned, which would infer a latch.
      state_d    = state_q;
      mask_d     = mask_q;
      select_d   = select;
      rst_done_d = 1'b0;
      busy_d     = busy;
      done_d     = done;
      pass_d     = pass;
      fail_map_d = fail_map;
      cur_algo_d = cur_algo;
      scan       = find_next(mask_q, cur_algo);

      case (state_q)
         ST_IDLE: begin
            if (start && !start_q) begin
               mask_d     = algo_mask;
               fail_map_d = '0;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               busy_d     = 1'b1;
               cur_algo_d = 3'd0;
               state_d    = (algo_mask == '0) ? ST_FINISH : ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (scan.found) begin
               cur_algo_d = scan.idx;
               select_d   = sel_code(scan.idx);
               state_d    = ST_ISSUE;
            end else begin
               state_d    = ST_FINISH;
            end
         end
         ST_ISSUE: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            // A finish reported in the expiry cycle still records algo_fail.
            if (algo_done || wd_expire) begin
               fail_map_d[cur_algo] = algo_done ? algo_fail : 1'b1;
               select_d             = SEL_NONE;
               rst_done_d           = 1'b1;
               state_d              = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            // Saturates one past the last slot so SCAN finds nothing; no wrap.
            if (cur_algo < 3'(NUM_ALGOS)) begin
               cur_algo_d = cur_algo + 3'd1;
            end
            state_d = ST_SCAN;
         end
         ST_FINISH: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = ~|fail_map;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
